// File: rtl/sop_sweep_ctrl.sv
// sop_sweep_ctrl: clocked self-check wrapper around a combinational SoP bank.
// Steps the bank through every minterm (0 .. 2^NIN-1) and captures each
// function output into a per-function minterm mask. The masks are then compared
// against exp_mask, and the sequence finishes with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   start       begin sweep (honoured only in IDLE)
//   step        (SOP_SWEEP_STEP_EN only) level gate to leave DRIVE
//   abort       synchronous cancel back to IDLE, no done pulse
//   drive       minterm index applied to the bank (MSB = x)
//   f_in        bank outputs, bit f = function f
//   exp_mask    expected masks, [f*2^NIN +: 2^NIN] per function
//   mask_out    captured masks, same layout as exp_mask
//   mismatch    per-function compare fail, valid from the done cycle on
//   busy        sweep in progress
//   done        one-cycle completion pulse
//   pass        no mismatches; held until the next start
//
// Optional feature macro: SOP_SWEEP_STEP_EN (adds the step input).

// One function lane: captures a function's minterm mask and reports whether
// it differs from the expected mask.
module sop_sweep_lane #(
  parameter int NIN = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               cap,
  input  logic [NIN-1:0]     idx,
  input  logic               f,
  input  logic [(1<<NIN)-1:0] exp_bits,
  output logic [(1<<NIN)-1:0] mask,
  output logic               diff
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   mask      <= '0;
    else if (clr) mask      <= '0;
    else if (cap) mask[idx] <= f;
  end

  // An X/Z sample propagates into diff on purpose, so it cannot read as a pass.
  assign diff = |(mask ^ exp_bits);
endmodule

module sop_sweep_ctrl #(
  parameter int NIN    = 3,
  parameter int NFUNC  = 5,
  parameter int SETTLE = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
`ifdef SOP_SWEEP_STEP_EN
  input  logic                        step,
`endif
  input  logic                        abort,
  output logic [NIN-1:0]              drive,
  input  logic [NFUNC-1:0]            f_in,
  input  logic [NFUNC*(1<<NIN)-1:0]   exp_mask,
  output logic [NFUNC*(1<<NIN)-1:0]   mask_out,
  output logic [NFUNC-1:0]            mismatch,
  output logic                        busy,
  output logic                        done,
  output logic                        pass
);
  localparam int M  = 1 << NIN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [NIN-1:0] LAST_MT  = NIN'(M - 1);

  // Without a settle count or step gate, DRIVE would take zero cycles. In that
  // case the FSM bypasses DRIVE, so each minterm costs exactly one cycle.
`ifdef SOP_SWEEP_STEP_EN
  localparam bit SKIP_DRIVE = 1'b0;
  wire go = step;
`else
  localparam bit SKIP_DRIVE = (SETTLE == 0);
  wire go = 1'b1;
`endif

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, CHECK} state_t;
  state_t state, nstate;

  logic [CW-1:0]    cnt;
  logic [NFUNC-1:0] diff;
  logic             accept, cap, chk, abrt, cnt_inc, cnt_clr;

  wire settled = (SETTLE == 0) || (cnt == CNT_LAST);
  wire last    = (drive == LAST_MT);
  localparam state_t AFTER_MT = SKIP_DRIVE ? SAMPLE : DRIVE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate  = state;
    accept  = 1'b0;
    cap     = 1'b0;
    chk     = 1'b0;
    abrt    = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    case (state)
      IDLE: if (start && !abort) begin
        accept = 1'b1;
        nstate = AFTER_MT;
      end
      DRIVE: begin
        if (!settled) cnt_inc = 1'b1;
        else if (go) begin
          cnt_clr = 1'b1;
          nstate  = SAMPLE;
        end
      end
      SAMPLE: begin
        cap    = 1'b1;
        nstate = last ? CHECK : AFTER_MT;
      end
      CHECK: begin
        chk    = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
    // abort overrides whatever the active state wanted to do this cycle
    if (state != IDLE && abort) begin
      nstate  = IDLE;
      abrt    = 1'b1;
      cap     = 1'b0;
      chk     = 1'b0;
      cnt_inc = 1'b0;
      cnt_clr = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drive    <= '0;
      cnt      <= '0;
      mismatch <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      done <= chk;
      if (abrt) begin
        drive <= '0;
        cnt   <= '0;
        busy  <= 1'b0;
        pass  <= 1'b0;
      end else begin
        if (accept) begin
          drive    <= '0;
          cnt      <= '0;
          mismatch <= '0;
          pass     <= 1'b0;
          busy     <= 1'b1;
        end
        if (cnt_inc) cnt <= cnt + CW'(1);
        if (cnt_clr) cnt <= '0;
        // no wrap: the last minterm leaves drive in place for CHECK
        if (cap && !last) drive <= drive + NIN'(1);
        if (chk) begin
          mismatch <= diff;
          pass     <= ~|diff;
          busy     <= 1'b0;
        end
      end
    end
  end

  for (genvar f = 0; f < NFUNC; f++) begin : g_lane
    sop_sweep_lane #(.NIN(NIN)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (accept),
      .cap      (cap),
      .idx      (drive),
      .f        (f_in[f]),
      .exp_bits (exp_mask[f*M +: M]),
      .mask     (mask_out[f*M +: M]),
      .diff     (diff[f])
    );
  end
endmodule

// File: tb/tb_sop_sweep_ctrl.sv
module tb_sop_sweep_ctrl;
  localparam int NIN = 3, NF = 5, M = 8, MW = NF * M;
  localparam logic [MW-1:0] GOOD = {8'hC5, 8'h8E, 8'hB4, 8'h54, 8'h8A};

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: SETTLE=1 instance, index 1: SETTLE=3 instance
  logic [1:0]           start = '0, abort = '0, step = '1;
  logic [1:0][NIN-1:0]  drive;
  logic [1:0][NF-1:0]   f_in;
  logic [1:0][MW-1:0]   mask_out;
  logic [1:0][NF-1:0]   mismatch;
  logic [1:0]           busy, done, pass;
  logic [MW-1:0]        exp_mask = '0;
  logic [NF-1:0]        bank_xor = '0;

  // Model of the SoP bank; bank_xor inverts selected functions to plant faults.
  always_comb
    for (int s = 0; s < 2; s++)
      for (int f = 0; f < NF; f++)
        f_in[s][f] = GOOD[f*M + int'(drive[s])] ^ bank_xor[f];

  sop_sweep_ctrl #(.NIN(NIN), .NFUNC(NF), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
`ifdef SOP_SWEEP_STEP_EN
    .step(step[0]),
`endif
    .abort(abort[0]), .drive(drive[0]), .f_in(f_in[0]), .exp_mask(exp_mask),
    .mask_out(mask_out[0]), .mismatch(mismatch[0]), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]));

  sop_sweep_ctrl #(.NIN(NIN), .NFUNC(NF), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
`ifdef SOP_SWEEP_STEP_EN
    .step(step[1]),
`endif
    .abort(abort[1]), .drive(drive[1]), .f_in(f_in[1]), .exp_mask(exp_mask),
    .mask_out(mask_out[1]), .mismatch(mismatch[1]), .busy(busy[1]),
    .done(done[1]), .pass(pass[1]));

  typedef struct { logic [MW-1:0] xm; logic [NF-1:0] bx; logic [NF-1:0] mm; logic ps; } vec_t;
  typedef struct { logic [NF-1:0] mm; logic ps; logic [MW-1:0] mask; int lat; } sb_t;

  vec_t vecs[4];
  sb_t  sbq[$];
  int   checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  function automatic logic [MW-1:0] captured(input logic [NF-1:0] bx);
    logic [MW-1:0] m;
    for (int f = 0; f < NF; f++) m[f*M +: M] = GOOD[f*M +: M] ^ {M{bx[f]}};
    return m;
  endfunction

  // Run one full sweep on instance sel; optionally re-pulse start at a minterm.
  task automatic run(input int sel, input int settle, input vec_t v, input int restart_at);
    sb_t e, got;
    int edges, bad, expd;
    bit seen, did;
    e.mm = v.mm; e.ps = v.ps; e.mask = captured(v.bx); e.lat = 1 + M*(settle+1) + 1;
    sbq.push_back(e);
    exp_mask = v.xm; bank_xor = v.bx;
    @(negedge clk); start[sel] = 1'b1;
    @(posedge clk); edges = 1;
    @(negedge clk); start[sel] = 1'b0;
    bad = 0; seen = 0; did = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (done[sel]) seen = 1;
      else begin
        expd = (edges-1 < M*(settle+1)) ? (edges-1)/(settle+1) : M-1;
        if (drive[sel] !== expd[NIN-1:0] || busy[sel] !== 1'b1) bad++;
        if (restart_at >= 0 && !did && int'(drive[sel]) == restart_at) begin
          start[sel] = 1'b1; did = 1;
        end
        @(posedge clk); edges++;
        @(negedge clk); start[sel] = 1'b0;
      end
    end
    got = sbq.pop_front();
    if (!seen) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done required=done_within_100");
    end else begin
      chk("latency",   edges,         got.lat);
      chk("mismatch",  mismatch[sel], got.mm);
      chk("pass",      pass[sel],     got.ps);
      chk("mask_out",  mask_out[sel], got.mask);
      chk("drive_seq", bad,           0);
      chk("busy_at_done", busy[sel],  1'b0);
      @(negedge clk);
      chk("done_pulse_width", done[sel], 1'b0);
      chk("pass_held", pass[sel], got.ps);
    end
  endtask

  task automatic wait_drive(input int sel, input int mt);
    int k;
    for (k = 0; k < 60 && int'(drive[sel]) != mt; k++) @(negedge clk);
    if (k == 60) begin
      checks++; failures++;
      $display("FAIL wait_drive actual=%0d required=%0d", drive[sel], mt);
    end
  endtask

  int ndone;

  initial begin
    vecs[0] = '{GOOD, 5'b00000, 5'b00000, 1'b1};
    vecs[1] = '{{8'hC5, 8'h8E, 8'hB5, 8'h54, 8'h8A}, 5'b00000, 5'b00100, 1'b0};
    vecs[2] = '{{8'h45, 8'h8E, 8'hB4, 8'h54, 8'h8B}, 5'b00000, 5'b10001, 1'b0};
    vecs[3] = '{GOOD, 5'b00010, 5'b00010, 1'b0};

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_drive", drive[s], 0);
      chk("rst_mask",  mask_out[s], 0);
      chk("rst_flags", {busy[s], done[s], pass[s], mismatch[s]}, 0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run(0, 1, vecs[i], -1);
    run(1, 3, vecs[0], -1);

    // start re-pulsed at minterm 3: ignored, exactly one done
    run(0, 1, vecs[0], 3);
    ndone = 0;
    repeat (20) begin @(negedge clk); if (done[0]) ndone++; end
    chk("restart_extra_done", ndone, 0);

    // abort at minterm 5: back to IDLE, partial mask kept, no done
    exp_mask = GOOD; bank_xor = '0;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    wait_drive(0, 5);
    abort[0] = 1'b1;
    @(negedge clk); abort[0] = 1'b0;
    chk("abort_state", {busy[0], done[0], pass[0], drive[0]}, 0);
    chk("abort_partial_mask", mask_out[0], GOOD & {NF{8'h1F}});
    ndone = 0;
    repeat (20) begin @(negedge clk); if (done[0]) ndone++; end
    chk("abort_no_done", ndone, 0);

    // reset at minterm 4: outputs clear without waiting for a clock edge
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    wait_drive(0, 4);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_drive", drive[0], 0);
    chk("midrst_mask",  mask_out[0], 0);
    chk("midrst_flags", {busy[0], done[0], pass[0], mismatch[0]}, 0);
    @(negedge clk); rst_n = 1'b1;
    run(0, 1, vecs[0], -1);

`ifdef SOP_SWEEP_STEP_EN
    step[0] = 1'b0; exp_mask = GOOD; bank_xor = '0;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("step_frozen", {busy[0], drive[0]}, {1'b1, 3'd0});
    ndone = 0;
    for (int p = 0; p < 8; p++) begin
      step[0] = 1'b1; @(negedge clk); step[0] = 1'b0;
      repeat (3) begin @(negedge clk); if (done[0]) ndone++; end
    end
    chk("step_done", ndone, 1);
    chk("step_pass", pass[0], 1'b1);
    step[0] = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
